// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle for the multicycle MIPS controller.
// master = controller side, slave = datapath/memory side.
interface multicycle_control_if #(
  parameter int ALUOP_WIDTH = 3,
  parameter int CNT_WIDTH   = 32
);
  logic [5:0]             op;
  logic [5:0]             funct;
  logic                   zero;
  logic                   mem_ready;
  logic                   pc_write;
  logic [1:0]             pc_src;
  logic                   ir_write;
  logic                   iord;
  logic                   mem_read;
  logic                   mem_write;
  logic                   reg_write;
  logic [1:0]             reg_dst;
  logic [1:0]             mem_to_reg;
  logic                   alu_src_a;
  logic [1:0]             alu_src_b;
  logic [ALUOP_WIDTH-1:0] alu_op;
  logic                   instr_done;
  logic [CNT_WIDTH-1:0]   retired;
  logic                   illegal_op;
  logic                   mem_timeout;
  logic                   trapped;

  modport master (
    input  op, funct, zero, mem_ready,
    output pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done,
           retired, illegal_op, mem_timeout, trapped
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done,
           retired, illegal_op, mem_timeout, trapped
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback over a
// shared memory port, with memory-wait watchdog, illegal-op trap and retire count.
module multicycle_control #(
  parameter int ALUOP_WIDTH  = 3,
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
                         ALU_WB = 4'd4, MEM_ADDR = 4'd5, MEM_READ = 4'd6, MEM_WB = 4'd7,
                         MEM_WRITE = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, JAL = 4'd11,
                         JR = 4'd12, TRAP = 4'd13;

  localparam logic [ALUOP_WIDTH-1:0] ALU_FN  = ALUOP_WIDTH'(3'b111);
  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD = ALUOP_WIDTH'(3'b100);
  localparam logic [ALUOP_WIDTH-1:0] ALU_OR  = ALUOP_WIDTH'(3'b101);
  localparam logic [ALUOP_WIDTH-1:0] ALU_AND = ALUOP_WIDTH'(3'b110);
  localparam logic [ALUOP_WIDTH-1:0] ALU_LUI = ALUOP_WIDTH'(3'b000);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB = ALUOP_WIDTH'(3'b001);

  localparam int WW = $clog2(MEM_WAIT_MAX + 1);

  logic [3:0]             state, nextState;
  logic [WW-1:0]          waitCnt;
  logic [CNT_WIDTH-1:0]   retiredQ;
  logic                   illegalQ, timeoutQ;
  logic                   waitState, timeout, illegalDec;
  logic                   pcWrite, irWrite, iord, memRead, memWrite, regWrite, aluSrcA, instrDone;
  logic [1:0]             pcSrc, regDst, memToReg, aluSrcB;
  logic [ALUOP_WIDTH-1:0] aluOp;

  assign waitState = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  // mem_ready arriving on the limit cycle still completes normally
  assign timeout   = waitState && (waitCnt == WW'(MEM_WAIT_MAX)) && !bus.mem_ready;

  always_comb begin
    nextState  = state;
    illegalDec = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 2'd0;
    irWrite    = 1'b0;
    iord       = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    regDst     = 2'd0;
    memToReg   = 2'd0;
    aluSrcA    = 1'b0;
    aluSrcB    = 2'd0;
    aluOp      = ALU_ADD;
    instrDone  = 1'b0;
    case (state)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'd1;
        if (bus.mem_ready) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        aluSrcB = 2'd3;
        case (bus.op)
          6'h00: begin
            if (bus.funct == 6'h08) nextState = JR;
            else if (bus.funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27})
              nextState = EXEC_R;
            else illegalDec = 1'b1;
          end
          6'h08, 6'h0c, 6'h0d, 6'h0f: nextState = EXEC_I;
          6'h23, 6'h2b:               nextState = MEM_ADDR;
          6'h04, 6'h05:               nextState = BRANCH;
          6'h02:                      nextState = JUMP;
          6'h03:                      nextState = JAL;
          default:                    illegalDec = 1'b1;
        endcase
        if (illegalDec) nextState = TRAP;
      end
      EXEC_R: begin
        aluSrcA   = 1'b1;
        aluOp     = ALU_FN;
        nextState = ALU_WB;
      end
      EXEC_I: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'd2;
        case (bus.op)
          6'h0c:   aluOp = ALU_AND;
          6'h0d:   aluOp = ALU_OR;
          6'h0f:   aluOp = ALU_LUI;
          default: aluOp = ALU_ADD;
        endcase
        nextState = ALU_WB;
      end
      ALU_WB: begin
        // IR is still held, so op tells R-type (rd) from I-type (rt)
        regWrite  = 1'b1;
        regDst    = (bus.op == 6'h00) ? 2'd1 : 2'd0;
        instrDone = 1'b1;
        nextState = FETCH;
      end
      MEM_ADDR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'd2;
        nextState = (bus.op == 6'h23) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        memRead = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ready) nextState = MEM_WB;
      end
      MEM_WB: begin
        regWrite  = 1'b1;
        memToReg  = 2'd1;
        instrDone = 1'b1;
        nextState = FETCH;
      end
      MEM_WRITE: begin
        memWrite = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) begin
          instrDone = 1'b1;
          nextState = FETCH;
        end
      end
      BRANCH: begin
        aluSrcA   = 1'b1;
        aluOp     = ALU_SUB;
        pcSrc     = 2'd1;
        pcWrite   = (bus.op == 6'h04) ? bus.zero : !bus.zero;
        instrDone = 1'b1;
        nextState = FETCH;
      end
      JUMP, JAL: begin
        pcWrite   = 1'b1;
        pcSrc     = 2'd2;
        instrDone = 1'b1;
        nextState = FETCH;
        if (state == JAL) begin
          regWrite = 1'b1;
          regDst   = 2'd2;
          memToReg = 2'd2;
        end
      end
      JR: begin
        aluSrcA   = 1'b1;
        pcWrite   = 1'b1;
        pcSrc     = 2'd3;
        instrDone = 1'b1;
        nextState = FETCH;
      end
      default: nextState = TRAP;
    endcase
    if (timeout) begin
      memRead   = 1'b0;
      memWrite  = 1'b0;
      irWrite   = 1'b0;
      pcWrite   = 1'b0;
      regWrite  = 1'b0;
      instrDone = 1'b0;
      nextState = TRAP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      waitCnt  <= '0;
      retiredQ <= '0;
      illegalQ <= 1'b0;
      timeoutQ <= 1'b0;
    end else begin
      state   <= nextState;
      waitCnt <= (waitState && !bus.mem_ready && !timeout) ? waitCnt + 1'b1 : '0;
      if (instrDone)  retiredQ <= retiredQ + 1'b1;
      if (illegalDec) illegalQ <= 1'b1;
      if (timeout)    timeoutQ <= 1'b1;
    end
  end

  assign bus.pc_write    = pcWrite;
  assign bus.pc_src      = pcSrc;
  assign bus.ir_write    = irWrite;
  assign bus.iord        = iord;
  assign bus.mem_read    = memRead;
  assign bus.mem_write   = memWrite;
  assign bus.reg_write   = regWrite;
  assign bus.reg_dst     = regDst;
  assign bus.mem_to_reg  = memToReg;
  assign bus.alu_src_a   = aluSrcA;
  assign bus.alu_src_b   = aluSrcB;
  assign bus.alu_op      = aluOp;
  assign bus.instr_done  = instrDone;
  assign bus.retired     = retiredQ;
  assign bus.illegal_op  = illegalQ;
  assign bus.mem_timeout = timeoutQ;
  assign bus.trapped     = (state == TRAP);
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: stimulus queues the expected final-state outputs of each
// instruction or trap; a negedge monitor pops and compares on instr_done/trap entry.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if #(.ALUOP_WIDTH(3), .CNT_WIDTH(4)) bus();

  multicycle_control #(.ALUOP_WIDTH(3), .MEM_WAIT_MAX(15), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int kind;  // 0 instruction retired, 1 trap entered
    int lat, pcWrite, pcSrc, regWrite, regDst, memToReg, memWrite, retired;
    int illegal, timeout;
  } exp_t;

  exp_t q[$];
  int   nChecks = 0;
  int   nPass   = 0;

  task automatic chk(input string name, input int act, input int req);
    nChecks++;
    if (act == req) nPass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  function automatic exp_t mkDone(int lat, int pw, int ps, int rw, int rd, int m2r, int mw, int ret);
    exp_t e;
    e = '{kind: 0, lat: lat, pcWrite: pw, pcSrc: ps, regWrite: rw, regDst: rd,
          memToReg: m2r, memWrite: mw, retired: ret, illegal: 0, timeout: 0};
    return e;
  endfunction

  function automatic exp_t mkTrap(int lat, int ill, int to);
    exp_t e;
    e = '{kind: 1, lat: lat, pcWrite: 0, pcSrc: 0, regWrite: 0, regDst: 0,
          memToReg: 0, memWrite: 0, retired: 0, illegal: ill, timeout: to};
    return e;
  endfunction

  // Monitor
  int   cyc = 0;
  logic prevTrap = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int   kind;
    if (reset) begin
      cyc      = 0;
      prevTrap = 1'b0;
    end else begin
      cyc++;
      if (bus.instr_done || (bus.trapped && !prevTrap)) begin
        kind = bus.instr_done ? 0 : 1;
        if (q.size() == 0) begin
          chk("unexpectedEvent", kind, -1);
        end else begin
          e = q.pop_front();
          chk("eventKind", kind, e.kind);
          chk("latency", cyc, e.lat);
          if (kind == 0 && e.kind == 0) begin
            chk("pc_write",   int'(bus.pc_write),   e.pcWrite);
            chk("pc_src",     int'(bus.pc_src),     e.pcSrc);
            chk("reg_write",  int'(bus.reg_write),  e.regWrite);
            chk("reg_dst",    int'(bus.reg_dst),    e.regDst);
            chk("mem_to_reg", int'(bus.mem_to_reg), e.memToReg);
            chk("mem_write",  int'(bus.mem_write),  e.memWrite);
            chk("retired",    int'(bus.retired),    e.retired);
          end else if (kind == 1 && e.kind == 1) begin
            chk("illegal_op",  int'(bus.illegal_op),  e.illegal);
            chk("mem_timeout", int'(bus.mem_timeout), e.timeout);
          end
        end
        cyc = 0;
      end
      prevTrap = bus.trapped;
    end
  end

  // Runs one instruction for a fixed number of cycles; mem_ready is low for
  // cycles lowFrom..lowTo. At cycle ckCyc the ALU select encoding
  // (src_a*256 + src_b*16 + alu_op) is compared to ckVal.
  task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input logic z,
                          input int cycles, input int lowFrom, input int lowTo,
                          input int ckCyc, input int ckVal, input exp_t e);
    bus.op    = o;
    bus.funct = f;
    bus.zero  = z;
    q.push_back(e);
    for (int c = 1; c <= cycles; c++) begin
      bus.mem_ready = !(c >= lowFrom && c <= lowTo);
      if (c == ckCyc)
        chk("aluSelect", int'(bus.alu_src_a) * 256 + int'(bus.alu_src_b) * 16 + int'(bus.alu_op), ckVal);
      @(posedge clk); #1;
    end
  endtask

  task automatic doReset();
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mem_read",    int'(bus.mem_read),    1);
    chk("rst_retired",     int'(bus.retired),     0);
    chk("rst_illegal_op",  int'(bus.illegal_op),  0);
    chk("rst_mem_timeout", int'(bus.mem_timeout), 0);
    chk("rst_trapped",     int'(bus.trapped),     0);
  endtask

  initial begin
    int holdCnt;
    reset = 1'b1;
    bus.op = 6'h00; bus.funct = 6'h20; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    doReset();

    //          op     funct  z  cyc lowF lowT ckC ckVal   expected final state
    runInstr(6'h00, 6'h20, 0,  4, 0, -1, 3, 'h107, mkDone(4, 0, 0, 1, 1, 0, 0, 0));  // ADD
    runInstr(6'h08, 6'h00, 0,  4, 0, -1, 3, 'h124, mkDone(4, 0, 0, 1, 0, 0, 0, 1));  // ADDI
    runInstr(6'h23, 6'h00, 0,  8, 4,  6, 5, 'h004, mkDone(8, 0, 0, 1, 0, 1, 0, 2));  // LW, 3 waits
    runInstr(6'h2b, 6'h00, 0,  4, 0, -1, 3, 'h124, mkDone(4, 0, 0, 0, 0, 0, 1, 3));  // SW
    runInstr(6'h04, 6'h00, 1,  3, 0, -1, 3, 'h101, mkDone(3, 1, 1, 0, 0, 0, 0, 4));  // BEQ taken
    runInstr(6'h05, 6'h00, 1,  3, 0, -1, 2, 'h034, mkDone(3, 0, 1, 0, 0, 0, 0, 5));  // BNE not taken
    runInstr(6'h02, 6'h00, 0,  3, 0, -1, 0, 0,     mkDone(3, 1, 2, 0, 0, 0, 0, 6));  // J
    runInstr(6'h03, 6'h00, 0,  3, 0, -1, 0, 0,     mkDone(3, 1, 2, 1, 2, 2, 0, 7));  // JAL
    runInstr(6'h00, 6'h08, 0,  3, 0, -1, 3, 'h104, mkDone(3, 1, 3, 0, 0, 0, 0, 8));  // JR
    runInstr(6'h0d, 6'h00, 0,  4, 0, -1, 3, 'h125, mkDone(4, 0, 0, 1, 0, 0, 0, 9));  // ORI
    runInstr(6'h0f, 6'h00, 0,  4, 0, -1, 3, 'h120, mkDone(4, 0, 0, 1, 0, 0, 0, 10)); // LUI
    runInstr(6'h0c, 6'h00, 0,  4, 0, -1, 3, 'h126, mkDone(4, 0, 0, 1, 0, 0, 0, 11)); // ANDI
    runInstr(6'h05, 6'h00, 0,  3, 0, -1, 0, 0,     mkDone(3, 1, 1, 0, 0, 0, 0, 12)); // BNE taken
    // fetch waits 15 cycles, ready arrives on the limit cycle: no trap
    runInstr(6'h00, 6'h22, 0, 19, 1, 15, 0, 0,     mkDone(19, 0, 0, 1, 1, 0, 0, 13));
    runInstr(6'h00, 6'h25, 0,  4, 0, -1, 0, 0,     mkDone(4, 0, 0, 1, 1, 0, 0, 14)); // OR
    runInstr(6'h00, 6'h2a, 0,  4, 0, -1, 0, 0,     mkDone(4, 0, 0, 1, 1, 0, 0, 15)); // SLT
    chk("retiredWrap", int'(bus.retired), 0);
    runInstr(6'h00, 6'h27, 0,  4, 0, -1, 0, 0,     mkDone(4, 0, 0, 1, 1, 0, 0, 0));  // NOR

    // illegal opcode: trap and hold
    runInstr(6'h3f, 6'h00, 0,  3, 0, -1, 0, 0, mkTrap(3, 1, 0));
    holdCnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.trapped && !bus.mem_read && !bus.pc_write && !bus.reg_write && !bus.ir_write)
        holdCnt++;
      @(posedge clk); #1;
    end
    chk("trapHold", holdCnt, 20);
    chk("trapRetired", int'(bus.retired), 1);
    doReset();

    // illegal funct on R-type
    runInstr(6'h00, 6'h3f, 0, 3, 0, -1, 0, 0, mkTrap(3, 1, 0));
    doReset();

    // fetch watchdog expiry
    bus.op = 6'h00; bus.funct = 6'h20;
    q.push_back(mkTrap(17, 0, 1));
    for (int c = 1; c <= 17; c++) begin
      bus.mem_ready = 1'b0;
      if (c == 15) chk("wdMemReadBefore", int'(bus.mem_read), 1);
      if (c == 16) chk("wdMemReadLimit",  int'(bus.mem_read), 0);
      @(posedge clk); #1;
    end
    chk("wdTrapped", int'(bus.trapped), 1);
    chk("wdFlag",    int'(bus.mem_timeout), 1);
    doReset();

    repeat (3) @(posedge clk);
    #1;
    chk("queueEmpty", q.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
